// File: rtl/bus_slave_responder.sv
// rtl/bus_slave_responder.sv - slave endpoint: local word memory, wait-stated reads, error/overrun flags
module bus_slave_responder #(
  parameter int address_length = 12,
  parameter int data_length    = 32,
  parameter int mem_addr_bits  = 8,
  parameter int read_wait      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [address_length-1:0] address_slave,
  input  logic [data_length-1:0]    data,
  input  logic                      wen,
  input  logic                      ren,
  output logic [data_length-1:0]    rdata,
  output logic                      rvalid,
  output logic                      wack,
  output logic                      busy,
  output logic                      err,
  output logic                      overrun
);

  localparam int          depth     = 2 ** mem_addr_bits;
  localparam logic [3:0]  wait_init = 4'(read_wait);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    READ_RESP = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [3:0]                r_cnt;
  logic [3:0]                w_cnt_next;
  logic [address_length-1:0] r_addr;
  logic [address_length-1:0] w_addr_next;
  logic [data_length-1:0]    r_mem [depth];

  logic [data_length-1:0]    r_rdata;
  logic                      r_rvalid;
  logic                      r_wack;
  logic                      r_busy;
  logic                      r_err;
  logic                      r_overrun;

  logic                      w_req_in_range;
  logic                      w_resp_in_range;
  logic                      w_mem_we;
  logic                      w_wr_ack;
  logic                      w_drop;
  logic                      w_resp;
  logic                      w_err_next;
  logic [data_length-1:0]    w_resp_data;

  assign w_req_in_range = ((address_slave >> mem_addr_bits) == '0);

  // Next-state / strobe decode; READ_RESP accepts a new request since rvalid drops on that edge
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_mem_we     = 1'b0;
    w_wr_ack     = 1'b0;
    w_drop       = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE, READ_RESP: begin
        w_state_next = IDLE;
        if (wen && ren) begin
          w_err_next = 1'b1;
        end else if (wen) begin
          w_wr_ack = 1'b1;
          if (w_req_in_range) w_mem_we = 1'b1;
          else                w_err_next = 1'b1;
        end else if (ren) begin
          w_addr_next  = address_slave;
          w_cnt_next   = wait_init;
          w_state_next = (wait_init == 4'd0) ? READ_RESP : READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (wen || ren) begin
          w_drop     = 1'b1;
          w_err_next = 1'b1;
        end
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_next = READ_RESP;
      end
      default: w_state_next = IDLE;
    endcase
    // Response data is fetched on the edge entering READ_RESP; w_addr_next covers the zero-wait case
    w_resp          = (w_state_next == READ_RESP);
    w_resp_in_range = ((w_addr_next >> mem_addr_bits) == '0);
    w_resp_data     = r_mem[w_addr_next[mem_addr_bits-1:0]];
    if (w_resp && !w_resp_in_range) w_err_next = 1'b1;
  end

  // State, counter, latched address and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_wack    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_addr    <= w_addr_next;
      r_rvalid  <= w_resp;
      r_wack    <= w_wr_ack;
      r_busy    <= (w_state_next != IDLE);
      r_err     <= w_err_next;
      r_overrun <= w_drop;
      if (w_resp) r_rdata <= w_resp_in_range ? w_resp_data : '0;
    end
  end

  // Memory write port; contents survive reset, but no write is taken while reset is asserted
  always_ff @(posedge clk) begin
    if (rst && w_mem_we) r_mem[address_slave[mem_addr_bits-1:0]] <= data;
  end

  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign wack    = r_wack;
  assign busy    = r_busy;
  assign err     = r_err;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_bus_slave_responder.sv
// tb/tb_bus_slave_responder.sv - directed vector bench for bus_slave_responder
module tb_bus_slave_responder;

  logic        clk;
  logic        rst,  wen,  ren;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid, wack, busy, err, overrun;

  logic        rst0, wen0, ren0;
  logic [11:0] addr0;
  logic [31:0] wdata0;
  logic [31:0] rdata0;
  logic        rvalid0, wack0, busy0, err0, overrun0;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        wen;
    logic        ren;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] e_rdata;
    logic        e_rvalid;
    logic        e_wack;
    logic        e_busy;
    logic        e_err;
    logic        e_ovr;
  } vec_t;

  vec_t vecs[$];

  bus_slave_responder #(
    .address_length(12), .data_length(32), .mem_addr_bits(8), .read_wait(2)
  ) u_dut (
    .clk(clk), .rst(rst), .address_slave(addr), .data(wdata), .wen(wen), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .wack(wack), .busy(busy), .err(err), .overrun(overrun)
  );

  bus_slave_responder #(
    .address_length(12), .data_length(32), .mem_addr_bits(8), .read_wait(0)
  ) u_dut0 (
    .clk(clk), .rst(rst0), .address_slave(addr0), .data(wdata0), .wen(wen0), .ren(ren0),
    .rdata(rdata0), .rvalid(rvalid0), .wack(wack0), .busy(busy0), .err(err0), .overrun(overrun0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic r, input logic w, input logic rd, input logic [11:0] a,
                     input logic [31:0] d, input logic [31:0] erd, input logic rv,
                     input logic wk, input logic bz, input logic er, input logic ov);
    vec_t v;
    v.rst = r; v.wen = w; v.ren = rd; v.addr = a; v.data = d;
    v.e_rdata = erd; v.e_rvalid = rv; v.e_wack = wk; v.e_busy = bz; v.e_err = er; v.e_ovr = ov;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic step0(input logic r, input logic w, input logic rd, input logic [11:0] a,
                       input logic [31:0] d);
    rst0 = r; wen0 = w; ren0 = rd; addr0 = a; wdata0 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
    rst0 = 1'b0; wen0 = 1'b0; ren0 = 1'b0; addr0 = '0; wdata0 = '0;

    // rst wen ren addr data | rdata rvalid wack busy err overrun (outputs in the cycle after the edge)
    add(0,0,0,12'h000,32'h0,        32'h0,       0,0,0,0,0);
    add(0,0,0,12'h000,32'h0,        32'h0,       0,0,0,0,0);
    add(1,1,0,12'h010,32'hA5,       32'h0,       0,1,0,0,0);
    add(0,0,0,12'h000,32'h0,        32'h0,       0,0,0,0,0);
    add(1,0,1,12'h010,32'h0,        32'h0,       0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'h0,       0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'hA5,      1,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'hA5,      0,0,0,0,0);
    add(1,1,0,12'h003,32'hDEADBEEF, 32'hA5,      0,1,0,0,0);
    add(1,0,1,12'h003,32'h0,        32'hA5,      0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'hA5,      0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'hDEADBEEF,1,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'hDEADBEEF,0,0,0,0,0);
    add(1,0,1,12'h100,32'h0,        32'hDEADBEEF,0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'hDEADBEEF,0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'h0,       1,0,1,1,0);
    add(1,1,0,12'h000,32'h11111111, 32'h0,       0,1,0,0,0);
    add(1,1,0,12'hF00,32'h12345678, 32'h0,       0,1,0,1,0);
    add(1,0,1,12'h000,32'h0,        32'h0,       0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'h0,       0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'h11111111,1,0,1,0,0);
    add(1,1,0,12'h001,32'hCAFEF00D, 32'h11111111,0,1,0,0,0);
    add(1,1,1,12'h001,32'h0,        32'h11111111,0,0,0,1,0);
    add(1,0,1,12'h001,32'h0,        32'h11111111,0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'h11111111,0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'hCAFEF00D,1,0,1,0,0);
    add(1,1,0,12'h002,32'h22,       32'hCAFEF00D,0,1,0,0,0);
    add(1,1,0,12'h004,32'h44,       32'hCAFEF00D,0,1,0,0,0);
    add(1,0,1,12'h002,32'h0,        32'hCAFEF00D,0,0,1,0,0);
    add(1,0,1,12'h004,32'h0,        32'hCAFEF00D,0,0,1,1,1);
    add(1,0,0,12'h000,32'h0,        32'h22,      1,0,1,0,0);
    add(1,0,1,12'h004,32'h0,        32'h22,      0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'h22,      0,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'h44,      1,0,1,0,0);
    add(1,0,0,12'h000,32'h0,        32'h44,      0,0,0,0,0);
    add(1,0,1,12'h003,32'h0,        32'h44,      0,0,1,0,0);
    add(0,0,0,12'h000,32'h0,        32'h0,       0,0,0,0,0);
    add(1,0,0,12'h000,32'h0,        32'h0,       0,0,0,0,0);
    add(1,0,0,12'h000,32'h0,        32'h0,       0,0,0,0,0);
    add(1,0,0,12'h000,32'h0,        32'h0,       0,0,0,0,0);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; wen = vecs[i].wen; ren = vecs[i].ren;
      addr = vecs[i].addr; wdata = vecs[i].data;
      @(posedge clk);
      #1;
      check("rdata",   i, rdata,          vecs[i].e_rdata);
      check("rvalid",  i, 32'(rvalid),    32'(vecs[i].e_rvalid));
      check("wack",    i, 32'(wack),      32'(vecs[i].e_wack));
      check("busy",    i, 32'(busy),      32'(vecs[i].e_busy));
      check("err",     i, 32'(err),       32'(vecs[i].e_err));
      check("overrun", i, 32'(overrun),   32'(vecs[i].e_ovr));
    end

    // Zero-wait-state build: response in the cycle right after ren, back-to-back reads on rvalid edges
    step0(0,0,0,12'h000,32'h0);
    check("rw0_reset_rvalid", 100, 32'(rvalid0), 32'h0);
    check("rw0_reset_busy",   100, 32'(busy0),   32'h0);
    check("rw0_reset_rdata",  100, rdata0,       32'h0);
    step0(1,1,0,12'h005,32'h55);
    check("rw0_wack",         101, 32'(wack0),   32'h1);
    step0(1,0,1,12'h005,32'h0);
    check("rw0_rvalid",       102, 32'(rvalid0), 32'h1);
    check("rw0_rdata",        102, rdata0,       32'h55);
    check("rw0_busy",         102, 32'(busy0),   32'h1);
    step0(1,0,1,12'h005,32'h0);
    check("rw0_b2b_rvalid",   103, 32'(rvalid0), 32'h1);
    check("rw0_b2b_overrun",  103, 32'(overrun0),32'h0);
    step0(1,1,0,12'h005,32'h66);
    check("rw0_wr_wack",      104, 32'(wack0),   32'h1);
    check("rw0_wr_rvalid",    104, 32'(rvalid0), 32'h0);
    check("rw0_wr_busy",      104, 32'(busy0),   32'h0);
    step0(1,0,1,12'h005,32'h0);
    check("rw0_new_rvalid",   105, 32'(rvalid0), 32'h1);
    check("rw0_new_rdata",    105, rdata0,       32'h66);
    step0(1,0,0,12'h000,32'h0);
    check("rw0_idle_rvalid",  106, 32'(rvalid0), 32'h0);
    check("rw0_idle_busy",    106, 32'(busy0),   32'h0);
    check("rw0_idle_rdata",   106, rdata0,       32'h66);
    check("rw0_idle_err",     106, 32'(err0),    32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
